motor_cmd_sequencer: RTL and testbench

Sits between the gesture-command receiver and the 2-channel PWM motor driver (left = A, right = B). Decodes accepted 4-bit commands into per-channel target duties. Ramps the live duties toward those targets at a fixed slew rate. Enforces a command watchdog (failsafe stop) and an emergency-stop input. Outputs 9-bit duties and a forward-enable for the driver's direction pins.

---
 rtl/motor_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_motor_cmd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sequencer.sv
// Two-channel motor command sequencer: decodes gesture nibbles into duty targets,
// slews live duties per tick, and handles watchdog failsafe and emergency stop.
// Define MOTOR_SEQ_KICK_EN to jump a stalled channel straight to a kick-start duty.
module motor_cmd_sequencer #(
    parameter int TICK_DIV    = 125000,
    parameter int RAMP_STEP   = 16,
    parameter int WDT_TICKS   = 500,
    parameter int DUTY_NORMAL = 400,
    parameter int DUTY_FAST   = 510,
    parameter int KICK_DUTY   = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_nibble,
    input  logic       estop,
    output logic [8:0] duty_a,
    output logic [8:0] duty_b,
    output logic       fwd_en,
    output logic [1:0] state,
    output logic       wdt_timeout
);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_RUN      = 2'b01;
    localparam logic [1:0] S_FAILSAFE = 2'b10;
    localparam logic [1:0] S_ESTOP    = 2'b11;

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WCW = $clog2(WDT_TICKS + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [WCW-1:0] WDT_LAST  = WCW'(WDT_TICKS - 1);
    localparam logic [9:0]     STEP      = 10'(RAMP_STEP);
`ifdef MOTOR_SEQ_KICK_EN
    localparam logic [9:0]     KICK      = 10'((KICK_DUTY > RAMP_STEP) ? KICK_DUTY : RAMP_STEP);
`endif

    logic [1:0]     state_q, state_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [WCW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic [8:0]     duty_a_q, duty_a_d, duty_b_q, duty_b_d;
    logic [8:0]     tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d;
    logic           fwd_en_q, fwd_en_d;
    logic           wdt_timeout_q, wdt_timeout_d;

    logic       tick, accept, base_nz, wdt_expire, stopped;
    logic [8:0] base, cmd_tgt_a, cmd_tgt_b;

    // Step cur toward tgt by at most STEP; 10-bit math so nothing wraps.
    function automatic logic [8:0] ramp_toward(input logic [8:0] cur, input logic [8:0] tgt);
        logic [9:0] c, t, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        r = c;
        if (c < t)
            r = ((t - c) <= STEP) ? t : c + STEP;
        else if (c > t)
            r = ((c - t) <= STEP) ? t : c - STEP;
`ifdef MOTOR_SEQ_KICK_EN
        if (c == 10'd0 && t != 10'd0)
            r = (KICK > t) ? t : KICK;
`endif
        return r[8:0];
    endfunction

    always_comb begin
        case (cmd_nibble[3:2])
            2'b01:   base = 9'(DUTY_NORMAL);
            2'b10:   base = 9'(DUTY_FAST);
            default: base = 9'd0;
        endcase
        cmd_tgt_a  = (cmd_nibble[1:0] == 2'b10) ? 9'd0 : base;
        cmd_tgt_b  = (cmd_nibble[1:0] == 2'b01) ? 9'd0 : base;
        base_nz    = |base;
        tick       = (tick_cnt_q == TICK_LAST);
        // In ESTOP only a stop command is taken; estop itself drops everything.
        accept     = cmd_valid && !estop && (state_q != S_ESTOP || cmd_nibble[3:2] == 2'b00);
        wdt_expire = (state_q == S_RUN) && tick && !accept && (wdt_cnt_q == WDT_LAST);
        stopped    = (tgt_a_q == 9'd0) && (tgt_b_q == 9'd0) && (duty_a_q == 9'd0) && (duty_b_q == 9'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            wdt_cnt_q     <= '0;
            duty_a_q      <= '0;
            duty_b_q      <= '0;
            tgt_a_q       <= '0;
            tgt_b_q       <= '0;
            fwd_en_q      <= 1'b0;
            wdt_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            wdt_cnt_q     <= wdt_cnt_d;
            duty_a_q      <= duty_a_d;
            duty_b_q      <= duty_b_d;
            tgt_a_q       <= tgt_a_d;
            tgt_b_q       <= tgt_b_d;
            fwd_en_q      <= fwd_en_d;
            wdt_timeout_q <= wdt_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (estop) begin
            state_d = S_ESTOP;
        end else begin
            case (state_q)
                S_IDLE:     if (accept && base_nz) state_d = S_RUN;
                S_RUN: begin
                    if (accept)          state_d = S_RUN;
                    else if (wdt_expire) state_d = S_FAILSAFE;
                    else if (stopped)    state_d = S_IDLE;
                end
                S_FAILSAFE: if (accept) state_d = base_nz ? S_RUN : S_IDLE;
                default:    if (accept) state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        duty_a_d      = tick ? ramp_toward(duty_a_q, tgt_a_q) : duty_a_q;
        duty_b_d      = tick ? ramp_toward(duty_b_q, tgt_b_q) : duty_b_q;
        tgt_a_d       = tgt_a_q;
        tgt_b_d       = tgt_b_q;
        wdt_cnt_d     = wdt_cnt_q;
        wdt_timeout_d = wdt_timeout_q;
        if (estop) begin
            duty_a_d  = '0;
            duty_b_d  = '0;
            tgt_a_d   = '0;
            tgt_b_d   = '0;
        end else if (accept) begin
            tgt_a_d       = cmd_tgt_a;
            tgt_b_d       = cmd_tgt_b;
            wdt_cnt_d     = '0;
            wdt_timeout_d = 1'b0;
        end else if (wdt_expire) begin
            tgt_a_d       = '0;
            tgt_b_d       = '0;
            wdt_timeout_d = 1'b1;
        end else if (state_q == S_RUN && tick) begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
        end
        if (state_d != S_RUN)
            wdt_cnt_d = '0;
        fwd_en_d = (state_d == S_RUN || state_d == S_FAILSAFE) &&
                   (|{duty_a_d, duty_b_d, tgt_a_d, tgt_b_d});
    end

    assign duty_a      = duty_a_q;
    assign duty_b      = duty_b_q;
    assign fwd_en      = fwd_en_q;
    assign state       = state_q;
    assign wdt_timeout = wdt_timeout_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Self-checking bench for motor_cmd_sequencer: directed scenarios plus random
// commands/estop pulses compared every cycle against a behavioural model.
module tb_motor_cmd_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int RAMP_STEP   = 100;
    localparam int WDT_TICKS   = 10;
    localparam int DUTY_NORMAL = 400;
    localparam int DUTY_FAST   = 510;
    localparam int KICK_DUTY   = 250;

    localparam int M_IDLE = 0, M_RUN = 1, M_FS = 2, M_ESTOP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_nibble = 4'd0;
    logic       estop = 1'b0;
    logic [8:0] duty_a, duty_b;
    logic       fwd_en;
    logic [1:0] state;
    logic       wdt_timeout;

    int checks = 0;
    int passes = 0;

    int m_tc, m_mode, m_da, m_db, m_ta, m_tb, m_wdt, m_wto, m_fwd;

    always #5 clk = ~clk;

    motor_cmd_sequencer #(
        .TICK_DIV(TICK_DIV), .RAMP_STEP(RAMP_STEP), .WDT_TICKS(WDT_TICKS),
        .DUTY_NORMAL(DUTY_NORMAL), .DUTY_FAST(DUTY_FAST), .KICK_DUTY(KICK_DUTY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_nibble(cmd_nibble),
        .estop(estop), .duty_a(duty_a), .duty_b(duty_b), .fwd_en(fwd_en),
        .state(state), .wdt_timeout(wdt_timeout)
    );

    function automatic int approach(input int cur, input int tgt);
`ifdef MOTOR_SEQ_KICK_EN
        int k;
        k = (KICK_DUTY > RAMP_STEP) ? KICK_DUTY : RAMP_STEP;
        if (cur == 0 && tgt > 0) return (k < tgt) ? k : tgt;
`endif
        if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
        if (cur > tgt) return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
        return cur;
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [8:0] a, b;
        logic [1:0] md;
        a = 9'(m_da);
        b = 9'(m_db);
        md = 2'(m_mode);
        return {a, b, m_fwd != 0, md, m_wto != 0};
    endfunction

    function automatic string q2s(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic model_reset();
        m_tc = 0; m_mode = M_IDLE; m_da = 0; m_db = 0; m_ta = 0; m_tb = 0;
        m_wdt = 0; m_wto = 0; m_fwd = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] n, input logic e);
        bit tick, acc;
        int spd, str, base, na, nb, oa, ob;
        tick  = (m_tc == TICK_DIV - 1);
        m_tc  = tick ? 0 : m_tc + 1;
        spd   = int'(n[3:2]);
        str   = int'(n[1:0]);
        base  = (spd == 1) ? DUTY_NORMAL : (spd == 2) ? DUTY_FAST : 0;
        na    = (str == 2) ? 0 : base;
        nb    = (str == 1) ? 0 : base;
        if (e) begin
            m_mode = M_ESTOP; m_da = 0; m_db = 0; m_ta = 0; m_tb = 0; m_wdt = 0;
        end else begin
            acc = v && (m_mode != M_ESTOP || spd == 0);
            oa = m_da;
            ob = m_db;
            if (tick) begin
                m_da = approach(m_da, m_ta);
                m_db = approach(m_db, m_tb);
            end
            if (acc) begin
                m_ta = na; m_tb = nb; m_wdt = 0; m_wto = 0;
                if (m_mode == M_ESTOP)     m_mode = M_IDLE;
                else if (m_mode != M_RUN)  m_mode = (base != 0) ? M_RUN : M_IDLE;
            end else if (m_mode == M_RUN) begin
                if (tick) m_wdt++;
                if (m_wdt == WDT_TICKS) begin
                    m_mode = M_FS; m_ta = 0; m_tb = 0; m_wto = 1;
                end else if (m_ta == 0 && m_tb == 0 && oa == 0 && ob == 0) begin
                    m_mode = M_IDLE;
                end
            end
            if (m_mode != M_RUN) m_wdt = 0;
        end
        m_fwd = ((m_mode == M_RUN || m_mode == M_FS) && (m_da | m_db | m_ta | m_tb) != 0) ? 1 : 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input logic v, input logic [3:0] n, input logic e);
        cmd_valid  = v;
        cmd_nibble = n;
        estop      = e;
        @(posedge clk);
        model_step(v, n, e);
        #1;
        if (v) $display("cmd %b estop %b -> state %0d duty %0d/%0d fwd %0d wdt %0d",
                        n, e, state, duty_a, duty_b, fwd_en, wdt_timeout);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== 22'd0)
            $display("FAIL reset_hold: got %h exp 0", {duty_a, duty_b, fwd_en, state, wdt_timeout});
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL reset_idle: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_ramp();
        int qa[$];
        int pa;
        string exp_s;
`ifdef MOTOR_SEQ_KICK_EN
        exp_s = "250 350 400 ";
`else
        exp_s = "100 200 300 400 ";
`endif
        pa = 0;
        cyc(1'b1, 4'b0100, 1'b0);
        checks++;
        if ({state, fwd_en} !== 3'b011)
            $display("FAIL ramp_accept: got state %0d fwd %0d exp state 1 fwd 1", state, fwd_en);
        else passes++;
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            if (int'(duty_a) != pa) begin qa.push_back(int'(duty_a)); pa = int'(duty_a); end
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL ramp_cycle: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
        checks++;
        if (q2s(qa) != exp_s) $display("FAIL ramp_seq: got %s exp %s", q2s(qa), exp_s);
        else passes++;
        checks++;
        if ({duty_a, duty_b} !== {9'd400, 9'd400})
            $display("FAIL ramp_hold: got %0d/%0d exp 400/400", duty_a, duty_b);
        else passes++;
    endtask

    task automatic test_steer_clamp();
        int qa[$], qb[$];
        int pa, pb;
        string exp_a, exp_b;
        exp_a = "300 200 100 0 ";
        exp_b = "500 510 ";
        pa = int'(duty_a);
        pb = int'(duty_b);
        cyc(1'b1, 4'b1010, 1'b0);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            if (int'(duty_a) != pa) begin qa.push_back(int'(duty_a)); pa = int'(duty_a); end
            if (int'(duty_b) != pb) begin qb.push_back(int'(duty_b)); pb = int'(duty_b); end
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL steer_cycle: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
        checks++;
        if (q2s(qa) != exp_a) $display("FAIL steer_seq_a: got %s exp %s", q2s(qa), exp_a);
        else passes++;
        checks++;
        if (q2s(qb) != exp_b) $display("FAIL steer_seq_b: got %s exp %s", q2s(qb), exp_b);
        else passes++;
    endtask

    task automatic test_watchdog();
        int n, pa;
        int qa[$];
        string exp_s;
        exp_s = "300 200 100 0 ";
        n = 0;
        cyc(1'b1, 4'b0100, 1'b0);
        while (state !== 2'b10 && n < 80) begin
            cyc(1'b0, 4'd0, 1'b0);
            n++;
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL wdt_cycle: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
        checks++;
        if (n < 37 || n > 40) $display("FAIL wdt_expiry_cycles: got %0d exp 37..40", n);
        else passes++;
        checks++;
        if ({state, wdt_timeout, fwd_en} !== 4'b1011)
            $display("FAIL wdt_flags: got state %0d wdt %0d fwd %0d exp 2 1 1", state, wdt_timeout, fwd_en);
        else passes++;
        pa = int'(duty_a);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            if (int'(duty_a) != pa) begin qa.push_back(int'(duty_a)); pa = int'(duty_a); end
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL wdt_down: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
        checks++;
        if (q2s(qa) != exp_s) $display("FAIL wdt_seq: got %s exp %s", q2s(qa), exp_s);
        else passes++;
        checks++;
        if ({state, fwd_en, duty_b} !== {2'b10, 1'b0, 9'd0})
            $display("FAIL wdt_rest: got state %0d fwd %0d duty_b %0d exp 2 0 0", state, fwd_en, duty_b);
        else passes++;
        cyc(1'b1, 4'b0100, 1'b0);
        checks++;
        if ({state, wdt_timeout} !== 3'b010)
            $display("FAIL wdt_recover: got state %0d wdt %0d exp 1 0", state, wdt_timeout);
        else passes++;
    endtask

    task automatic test_estop();
        repeat (17) cyc(1'b0, 4'd0, 1'b0);
        checks++;
        if ({duty_a, duty_b} !== {9'd400, 9'd400})
            $display("FAIL estop_pre: got %0d/%0d exp 400/400", duty_a, duty_b);
        else passes++;
        cyc(1'b1, 4'b0100, 1'b1);
        checks++;
        if ({duty_a, duty_b, fwd_en, state} !== {9'd0, 9'd0, 1'b0, 2'b11})
            $display("FAIL estop_hit: got %0d/%0d fwd %0d state %0d exp 0/0 0 3", duty_a, duty_b, fwd_en, state);
        else passes++;
        repeat (2) cyc(1'b0, 4'd0, 1'b1);
        repeat (2) cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0);
        checks++;
        if ({duty_a, duty_b, fwd_en, state} !== {9'd0, 9'd0, 1'b0, 2'b11})
            $display("FAIL estop_ignore: got %0d/%0d fwd %0d state %0d exp 0/0 0 3", duty_a, duty_b, fwd_en, state);
        else passes++;
        cyc(1'b1, 4'b0000, 1'b0);
        checks++;
        if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec() || state !== 2'b00)
            $display("FAIL estop_release: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
        else passes++;
    endtask

    task automatic test_reset_mid_ramp();
        int n;
        n = 0;
        cyc(1'b1, 4'b0100, 1'b0);
        while (duty_a !== 9'd200 && n < 20) begin
            cyc(1'b0, 4'd0, 1'b0);
            n++;
        end
        checks++;
        if (duty_a !== 9'd200) $display("FAIL rst_reach200: got %0d exp 200", duty_a);
        else passes++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== 22'd0)
            $display("FAIL rst_async: got %h exp 0", {duty_a, duty_b, fwd_en, state, wdt_timeout});
        else passes++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== 22'd0 ||
                {duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL rst_still: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_cmd_at_expiry();
        bit hit;
        hit = 0;
        cyc(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (m_wdt == WDT_TICKS - 1 && m_tc == TICK_DIV - 1 && m_mode == M_RUN) begin
                hit = 1;
                break;
            end
            cyc(1'b0, 4'd0, 1'b0);
        end
        checks++;
        if (!hit) $display("FAIL expiry_reach: got no expiry window exp one within 60 cycles");
        else passes++;
        cyc(1'b1, 4'b0101, 1'b0);
        checks++;
        if ({state, wdt_timeout} !== 3'b010 || {duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
            $display("FAIL expiry_cmd_wins: got %h exp %h", {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
        else passes++;
    endtask

    task automatic test_random();
        int estop_left;
        logic v, e, pv;
        logic [3:0] n;
        estop_left = 0;
        pv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (estop_left == 0 && $urandom_range(0, 299) == 0) estop_left = $urandom_range(1, 5);
            e = (estop_left > 0);
            if (estop_left > 0) estop_left--;
            v = ($urandom_range(0, 39) == 0) || (pv && $urandom_range(0, 2) == 0);
            n = 4'($urandom);
            pv = v;
            cyc(v, n, e);
            checks++;
            if ({duty_a, duty_b, fwd_en, state, wdt_timeout} !== exp_vec())
                $display("FAIL random_cycle %0d: got %h exp %h", i, {duty_a, duty_b, fwd_en, state, wdt_timeout}, exp_vec());
            else passes++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_steer_clamp();
        test_watchdog();
        test_estop();
        test_reset_mid_ramp();
        test_cmd_at_expiry();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no completion exp finish before 500000 ns");
        $fatal(1);
    end

endmodule
